// File: rtl/parity_rx_checker.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Checks parity and the stop bit, and reports each completed frame with a one-cycle valid pulse.
module parity_rx_checker #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 sin,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int   CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic ODD   = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_ins;
   logic                 r_par;
   logic                 r_par_bit;
   logic                 w_last_bit;
   logic                 w_exp_par;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;

   assign w_last_bit = (r_cnt == CNT_W'(DATA_BITS - 1));
   assign w_exp_par  = r_par ^ ODD;

   // Write the sampled bit into the slot selected by the counter.
   always_comb begin
      w_shift_ins = r_shift;
      for (int unsigned i = 0; i < DATA_BITS; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_shift_ins[i] = sin;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (tick) begin
         case (r_state)
            IDLE:    if (!sin) w_next_state = DATA;
            DATA:    if (w_last_bit) w_next_state = PARITY;
            PARITY:  w_next_state = STOP;
            STOP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_par_bit    <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (tick) begin
            case (r_state)
               IDLE: begin
                  if (!sin) begin
                     r_cnt   <= '0;
                     r_shift <= '0;
                     r_par   <= 1'b0;
                  end
               end
               DATA: begin
                  r_shift <= w_shift_ins;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_par   <= r_par ^ sin;
               end
               PARITY: begin
                  r_par_bit <= sin;
               end
               STOP: begin
                  r_data       <= r_shift;
                  r_parity_err <= (r_par_bit != w_exp_par);
                  r_frame_err  <= ~sin;
                  r_valid      <= 1'b1;
               end
               default: begin
                  r_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign data_out   = r_data;
   assign valid      = r_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_rx_checker.sv
// Directed bench for parity_rx_checker: an even-parity and an odd-parity instance share one serial line.
module tb_parity_rx_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       sin;

   logic [7:0] e_data;
   logic       e_valid, e_perr, e_ferr, e_busy;
   logic [7:0] o_data;
   logic       o_valid, o_perr, o_ferr, o_busy;

   int checks   = 0;
   int failures = 0;
   int e_vcnt   = 0;
   int o_vcnt   = 0;
   int busy_bad = 0;

   parity_rx_checker #(.DATA_BITS(8), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst_n(rst_n), .tick(tick), .sin(sin),
      .data_out(e_data), .valid(e_valid), .parity_err(e_perr),
      .frame_err(e_ferr), .busy(e_busy)
   );

   parity_rx_checker #(.DATA_BITS(8), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tick(tick), .sin(sin),
      .data_out(o_data), .valid(o_valid), .parity_err(o_perr),
      .frame_err(o_ferr), .busy(o_busy)
   );

   always #5 clk = ~clk;

   // Count the cycles in which valid is high.
   always @(negedge clk) begin
      if (e_valid === 1'b1) e_vcnt++;
      if (o_valid === 1'b1) o_vcnt++;
   end

   // One bit lasting p clocks; tick is high on the first of them only, and sin is inverted during the gap.
   task automatic send_bit(input logic b, input int p, input logic eb);
      sin  = b;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      sin  = ~b;
      if (e_busy !== eb || o_busy !== eb) busy_bad++;
      repeat (p - 1) begin
         @(negedge clk);
         if (e_busy !== eb || o_busy !== eb) busy_bad++;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                             input int p, input int idle);
      send_bit(1'b0, p, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(d[i], p, 1'b1);
      send_bit(pb, p, 1'b1);
      send_bit(sb, p, 1'b0);
      sin = 1'b1;
      repeat (idle) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick  = 1'b0;
      sin   = 1'b1;
      #12;
      checks++;
      if ({e_data, e_valid, e_perr, e_ferr, e_busy} !== 12'h000) begin
         failures++;
         $display("FAIL reset_even got=%h exp=000", {e_data, e_valid, e_perr, e_ferr, e_busy});
      end
      checks++;
      if ({o_data, o_valid, o_perr, o_ferr, o_busy} !== 12'h000) begin
         failures++;
         $display("FAIL reset_odd got=%h exp=000", {o_data, o_valid, o_perr, o_ferr, o_busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle;
      int v0;
      v0 = e_vcnt;
      busy_bad = 0;
      repeat (5) send_bit(1'b1, 1, 1'b0);
      sin = 1'b1;
      checks++;
      if (busy_bad !== 0 || e_vcnt !== v0) begin
         failures++;
         $display("FAIL idle_stays got busy_bad=%0d valids=%0d exp 0 0", busy_bad, e_vcnt - v0);
      end
   endtask

   task automatic test_basic;
      int v0;
      v0 = e_vcnt;
      busy_bad = 0;
      send_frame(8'hA5, 1'b0, 1'b1, 1, 2);
      checks++;
      if (e_data !== 8'hA5) begin
         failures++;
         $display("FAIL basic_data got=%h exp=a5", e_data);
      end
      checks++;
      if (e_perr !== 1'b0 || e_ferr !== 1'b0) begin
         failures++;
         $display("FAIL basic_flags got=%b%b exp=00", e_perr, e_ferr);
      end
      checks++;
      if (e_vcnt - v0 !== 1) begin
         failures++;
         $display("FAIL basic_valid_cycles got=%0d exp=1", e_vcnt - v0);
      end
      checks++;
      if (busy_bad !== 0) begin
         failures++;
         $display("FAIL basic_busy got=%0d bad samples exp=0", busy_bad);
      end
   endtask

   task automatic test_parity_err;
      int v0;
      v0 = e_vcnt;
      send_frame(8'h01, 1'b0, 1'b1, 1, 2);
      checks++;
      if (e_data !== 8'h01 || e_perr !== 1'b1 || e_ferr !== 1'b0) begin
         failures++;
         $display("FAIL parity_err got data=%h perr=%b ferr=%b exp 01 1 0", e_data, e_perr, e_ferr);
      end
      checks++;
      if (e_vcnt - v0 !== 1) begin
         failures++;
         $display("FAIL parity_err_valid got=%0d exp=1", e_vcnt - v0);
      end
      // Odd instance expects parity 0 for 0x01, so it sees no error.
      checks++;
      if (o_perr !== 1'b0) begin
         failures++;
         $display("FAIL parity_err_odd got=%b exp=0", o_perr);
      end
   endtask

   task automatic test_frame_err;
      int v0;
      v0 = e_vcnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1, 3);
      checks++;
      if (e_data !== 8'h3C || e_perr !== 1'b0 || e_ferr !== 1'b1) begin
         failures++;
         $display("FAIL frame_err got data=%h perr=%b ferr=%b exp 3c 0 1", e_data, e_perr, e_ferr);
      end
      checks++;
      if (e_vcnt - v0 !== 1) begin
         failures++;
         $display("FAIL frame_err_valid got=%0d exp=1", e_vcnt - v0);
      end
      send_frame(8'hFF, 1'b0, 1'b1, 1, 2);
      checks++;
      if (e_data !== 8'hFF || e_perr !== 1'b0 || e_ferr !== 1'b0) begin
         failures++;
         $display("FAIL frame_err_clear got data=%h perr=%b ferr=%b exp ff 0 0", e_data, e_perr, e_ferr);
      end
   endtask

   task automatic test_back_to_back;
      int v0;
      v0 = e_vcnt;
      send_frame(8'h12, 1'b0, 1'b1, 1, 0);
      checks++;
      if (e_data !== 8'h12 || e_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first got data=%h valid=%b exp 12 1", e_data, e_valid);
      end
      send_frame(8'h34, 1'b1, 1'b1, 1, 2);
      checks++;
      if (e_data !== 8'h34 || e_perr !== 1'b0 || e_ferr !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second got data=%h perr=%b ferr=%b exp 34 0 0", e_data, e_perr, e_ferr);
      end
      checks++;
      if (e_vcnt - v0 !== 2) begin
         failures++;
         $display("FAIL b2b_valid_count got=%0d exp=2", e_vcnt - v0);
      end
      checks++;
      if (o_perr !== 1'b1) begin
         failures++;
         $display("FAIL b2b_odd_perr got=%b exp=1", o_perr);
      end
   endtask

   task automatic test_reset_mid_frame;
      int v0;
      v0 = e_vcnt;
      send_bit(1'b0, 1, 1'b1);
      send_bit(1'b1, 1, 1'b1);
      send_bit(1'b0, 1, 1'b1);
      send_bit(1'b1, 1, 1'b1);
      send_bit(1'b1, 1, 1'b1);
      sin = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({e_data, e_valid, e_perr, e_ferr, e_busy} !== 12'h000) begin
         failures++;
         $display("FAIL rst_mid_even got=%h exp=000", {e_data, e_valid, e_perr, e_ferr, e_busy});
      end
      checks++;
      if ({o_data, o_valid, o_perr, o_ferr, o_busy} !== 12'h000) begin
         failures++;
         $display("FAIL rst_mid_odd got=%h exp=000", {o_data, o_valid, o_perr, o_ferr, o_busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) send_bit(1'b1, 1, 1'b0);
      checks++;
      if (e_vcnt !== v0 || e_busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_no_valid got valids=%0d busy=%b exp 0 0", e_vcnt - v0, e_busy);
      end
      send_frame(8'h5A, 1'b0, 1'b1, 1, 2);
      checks++;
      if (e_data !== 8'h5A || e_perr !== 1'b0 || e_ferr !== 1'b0 || e_vcnt - v0 !== 1) begin
         failures++;
         $display("FAIL rst_mid_resume got data=%h perr=%b ferr=%b valids=%0d exp 5a 0 0 1",
                  e_data, e_perr, e_ferr, e_vcnt - v0);
      end
   endtask

   task automatic test_odd_slow;
      int v0;
      v0 = o_vcnt;
      busy_bad = 0;
      send_frame(8'h00, 1'b1, 1'b1, 4, 6);
      checks++;
      if (o_data !== 8'h00 || o_perr !== 1'b0 || o_ferr !== 1'b0) begin
         failures++;
         $display("FAIL odd_slow got data=%h perr=%b ferr=%b exp 00 0 0", o_data, o_perr, o_ferr);
      end
      checks++;
      if (o_vcnt - v0 !== 1) begin
         failures++;
         $display("FAIL odd_slow_valid got=%0d exp=1", o_vcnt - v0);
      end
      checks++;
      if (busy_bad !== 0) begin
         failures++;
         $display("FAIL odd_slow_busy got=%0d bad samples exp=0", busy_bad);
      end
      checks++;
      if (e_data !== 8'h00 || e_perr !== 1'b1) begin
         failures++;
         $display("FAIL odd_slow_even got data=%h perr=%b exp 00 1", e_data, e_perr);
      end
   endtask

   initial begin
      test_reset;
      test_idle;
      test_basic;
      test_parity_err;
      test_frame_err;
      test_back_to_back;
      test_reset_mid_frame;
      test_odd_slow;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_rx_checker.md
PARITY_RX_CHECKER -- requirements
Module: parity_rx_checker

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 1..16.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  bit-sample strobe; sin is sampled only on clock edges where tick=1.
REQ-006 sin  input  1  serial line; idle level 1.
REQ-007 data_out  output  DATA_BITS  last received data word.
REQ-008 valid  output  1  one-cycle pulse marking frame completion.
REQ-009 parity_err  output  1  parity mismatch flag for the last frame.
REQ-010 frame_err  output  1  stop-bit error flag for the last frame.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 Frame format, in sin order: start bit (0), DATA_BITS data bits LSB first, one parity bit, stop bit (1).
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP; it changes state only on tick=1 edges.
REQ-014 IDLE, tick=1, sin=0: start bit consumed, bit counter cleared, go to DATA; IDLE with sin=1 stays in IDLE.
REQ-015 DATA: each tick shifts sin into the shift register at bit position = counter (LSB first) and increments the counter; after DATA_BITS ticks, go to PARITY.
REQ-016 PARITY: on tick, capture sin as the parity bit and go to STOP.
REQ-017 The running parity SHALL be the XOR of all data bits; expected parity bit = running parity XOR PARITY_ODD.
REQ-018 STOP, on tick, same edge for all of the following:
  - data_out <= shift register
  - parity_err <= (captured parity bit != expected parity bit)
  - frame_err <= (sin == 0)
  - valid <= 1
  - go to IDLE
REQ-019 valid SHALL be high for exactly one clock cycle, the cycle following the stop-bit sampling edge, regardless of tick.
REQ-020 A frame with frame_err=1 SHALL still pulse valid and update data_out and parity_err.
REQ-021 data_out, parity_err and frame_err SHALL hold their values until the next frame completion.
REQ-022 tick=0 cycles SHALL not alter the state, counter, shift register or running parity; arbitrary gaps between ticks are legal.
REQ-023 The block accepts back-to-back frames: a start bit on the first tick after STOP is accepted from IDLE.
REQ-024 busy SHALL be 1 from the clock edge entering DATA through the clock edge returning to IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock edge, force:
  - state IDLE
  - counter, shift register and running parity to 0
  - data_out=0, valid=0, parity_err=0, frame_err=0, busy=0
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid pulse; reception resumes at the next start bit after rst_n=1.

Verification
REQ-027 Default parameters, tick every clock, frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> data_out=0xA5, valid high exactly 1 cycle, parity_err=0, frame_err=0.
REQ-028 Frame 0x01 sent with parity bit 0 -> valid pulse, data_out=0x01, parity_err=1, frame_err=0.
REQ-029 Frame 0x3C, correct parity 0, stop bit 0 -> valid pulse, data_out=0x3C, parity_err=0, frame_err=1; next frame 0xFF with parity 0 and stop 1 -> both flags 0.
REQ-030 PARITY_ODD=1, frame 0x00 with parity bit 1, tick asserted every 4th clock -> data_out=0x00, parity_err=0, valid 1 cycle wide, busy high throughout the frame.
REQ-031 rst_n pulsed low after 4 data bits of a frame -> busy=0 and all outputs 0 immediately, no valid pulse; following frame 0x5A received with data_out=0x5A and no errors.
REQ-032 Two frames back-to-back (0x12 then 0x34, no idle bits between them) -> two valid pulses, data_out 0x12 then 0x34, no errors.
